led_counter: RTL and testbench

Consumer stage directly downstream of `blinker`. It turns each rising edge of the `blink` pulse train into one step of a WIDTH-bit binary count driven onto the board LEDs. Two push-buttons are synchronised and debounced: one pauses/resumes counting, the other reverses direction. Purely synchronous, single clock domain shared with `blinker`.

---
 rtl/led_counter.sv | 99 +++++++++
 tb/tb_led_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/led_counter.sv
// LED step counter fed by the blinker pulse train, with debounced pause and
// direction push-buttons. Single clock domain, synchronous active-low reset.
module led_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned DEB_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink,
  input  logic             btn_pause,
  input  logic             btn_dir,
  output logic [WIDTH-1:0] leds,
  output logic             dir,
  output logic             paused,
  output logic             wrap
);

  localparam int unsigned NCH      = 2;
  localparam int unsigned CH_PAUSE = 0;
  localparam int unsigned CH_DIR   = 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [NCH-1:0]   btn_raw_c;
  logic [NCH-1:0]   sync_a;
  logic [NCH-1:0]   sync_b;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   press_c;
  logic [DEB_W-1:0] cnt [NCH];

  logic             blink_q;
  logic             step_c;
  logic [WIDTH-1:0] leds_next_c;
  logic             wrap_next_c;

  assign btn_raw_c = {btn_dir, btn_pause};
  assign press_c   = stable & ~stable_q;
  assign step_c    = blink & ~blink_q;

  // Button channels: 2-FF synchroniser, debouncer, delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a   <= '0;
      sync_b   <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      sync_a   <= btn_raw_c;
      sync_b   <= sync_a;
      stable_q <= stable;
      for (int i = 0; i < NCH; i++) begin
        if (sync_b[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          stable[i] <= sync_b[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Next count and wrap flag; old dir/paused are used even when a toggle lands
  always_comb begin
    leds_next_c = leds;
    wrap_next_c = 1'b0;
    if (step_c && !paused) begin
      if (!dir) begin
        leds_next_c = leds + WIDTH'(1);
        wrap_next_c = (leds == ALL_ONES);
      end else begin
        leds_next_c = leds - WIDTH'(1);
        wrap_next_c = (leds == '0);
      end
    end
  end

  // Blink edge history (reset high so a level already present is not a step)
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_q <= 1'b1;
      leds    <= '0;
      wrap    <= 1'b0;
      dir     <= 1'b0;
      paused  <= 1'b0;
    end else begin
      blink_q <= blink;
      leds    <= leds_next_c;
      wrap    <= wrap_next_c;
      dir     <= dir ^ press_c[CH_DIR];
      paused  <= paused ^ press_c[CH_PAUSE];
    end
  end

endmodule

// File: tb/tb_led_counter.sv
// Randomised and directed bench for led_counter against an arithmetic model
// of the count, debounce-acceptance and toggle rules.
module tb_led_counter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEB   = 4;
  localparam int          MODV  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             blink;
  logic             btn_pause;
  logic             btn_dir;
  logic [WIDTH-1:0] leds;
  logic             dir;
  logic             paused;
  logic             wrap;

  int total = 0;
  int bad   = 0;

  led_counter #(.WIDTH(WIDTH), .DEB_CYCLES(DEB), .DEB_W(16)) dut (
    .clk(clk), .rst(rst), .blink(blink), .btn_pause(btn_pause), .btn_dir(btn_dir),
    .leds(leds), .dir(dir), .paused(paused), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw button seen two edges late, accepted after DEB
  // consecutive disagreeing edges, and the acceptance of a high level
  // toggles the target on the following edge.
  int       m_leds;
  bit       m_dir, m_paused, m_wrap, m_bprev, m_valid;
  bit [1:0] m_s1, m_s2, m_stab, m_pend;
  int       m_run [2];

  always @(posedge clk) begin : model
    bit       stp;
    int       nxt;
    bit [1:0] raw;
    if (rst === 1'b0) begin
      m_leds = 0; m_dir = 0; m_paused = 0; m_wrap = 0; m_bprev = 1;
      m_s1 = 0; m_s2 = 0; m_stab = 0; m_pend = 0;
      m_run[0] = 0; m_run[1] = 0;
      m_valid = 1;
    end else if (m_valid) begin
      raw = {btn_dir, btn_pause};
      stp = blink && !m_bprev;
      m_bprev = blink;
      m_wrap = 0;
      if (stp && !m_paused) begin
        nxt    = m_leds + (m_dir ? -1 : 1);
        m_wrap = (nxt < 0) || (nxt >= MODV);
        m_leds = (nxt + MODV) % MODV;
      end
      if (m_pend[0]) m_paused = !m_paused;
      if (m_pend[1]) m_dir = !m_dir;
      m_pend = 0;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_stab[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stab[i] = m_s2[i];
            m_run[i]  = 0;
            m_pend[i] = m_s2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("leds_model",   32'(leds),   32'(m_leds));
      chk("dir_model",    32'(dir),    32'(m_dir));
      chk("paused_model", 32'(paused), 32'(m_paused));
      chk("wrap_model",   32'(wrap),   32'(m_wrap));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    blink = 1'b0;
    cyc(1);
    blink = 1'b1;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; blink = 1'b0; btn_pause = 1'b0; btn_dir = 1'b0;
    @(negedge clk);

    // Reset with blink toggling, release with blink already high
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      blink = ~blink;
      cyc(1);
    end
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_dir", 32'(dir), 32'h0);
    chk("rst_paused", 32'(paused), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    blink = 1'b1; rst = 1'b1;
    cyc(3);
    chk("no_step_after_rst", 32'(leds), 32'h0);

    // Up count, preload to 0xFE, then wrap
    repeat (3) pulse();
    chk("three_pulses", 32'(leds), 32'h03);
    repeat (251) pulse();
    chk("preload_fe", 32'(leds), 32'hFE);
    pulse();
    chk("reach_ff", 32'(leds), 32'hFF);
    blink = 1'b0; cyc(1); blink = 1'b1; cyc(1);
    chk("wrap_leds", 32'(leds), 32'h00);
    chk("wrap_pulse", 32'(wrap), 32'h1);
    cyc(1);
    chk("wrap_one_cycle", 32'(wrap), 32'h0);

    // Pause press: toggle visible after edge DEB+3
    btn_pause = 1'b1;
    cyc(DEB + 2);
    chk("pause_not_yet", 32'(paused), 32'h0);
    cyc(1);
    chk("pause_edge7", 32'(paused), 32'h1);
    repeat (5) pulse();
    chk("paused_frozen", 32'(leds), 32'h00);
    btn_pause = 1'b0; cyc(10);
    btn_pause = 1'b1; cyc(10);
    btn_pause = 1'b0; cyc(10);
    chk("resume", 32'(paused), 32'h0);
    pulse();
    chk("resume_count", 32'(leds), 32'h01);

    // Glitch on dir shorter than the debounce window
    btn_dir = 1'b1; cyc(3);
    btn_dir = 1'b0; cyc(10);
    chk("glitch_dir", 32'(dir), 32'h0);
    pulse();
    chk("glitch_count_up", 32'(leds), 32'h02);

    // Down wrap from zero
    rst = 1'b0; cyc(1); rst = 1'b1;
    btn_dir = 1'b1; cyc(10);
    btn_dir = 1'b0; cyc(10);
    chk("dir_down", 32'(dir), 32'h1);
    pulse();
    chk("down_wrap_leds", 32'(leds), 32'hFF);
    chk("down_wrap_pulse", 32'(wrap), 32'h1);

    // Step on the same edge as the dir toggle counts in the old direction
    btn_dir = 1'b1;
    cyc(DEB + 1);
    blink = 1'b0; cyc(1);
    blink = 1'b1; cyc(1);
    chk("simul_leds", 32'(leds), 32'hFE);
    chk("simul_dir", 32'(dir), 32'h0);
    btn_dir = 1'b0; cyc(12);

    // Reset mid-debounce, button still held afterwards
    btn_pause = 1'b1;
    cyc(2);
    rst = 1'b0; cyc(1); rst = 1'b1;
    chk("middeb_paused", 32'(paused), 32'h0);
    chk("middeb_leds", 32'(leds), 32'h0);
    cyc(DEB + 2);
    chk("redeb_not_yet", 32'(paused), 32'h0);
    cyc(1);
    chk("redeb_paused", 32'(paused), 32'h1);
    btn_pause = 1'b0; cyc(10);

    // Randomised traffic: blink noise, slowly flipping buttons, rare resets
    for (int i = 0; i < 3000; i++) begin
      blink = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 15) == 0) btn_dir = ~btn_dir;
      rst = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    rst = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
